// File: rtl/instruction_fetch_unit.sv
// Fetch stage for the single-cycle LEGv8 datapath: owns the PC, fetches one word at a time over req/ack, buffers it.
// Optional performance counters are enabled with `define FETCH_PERF_EN.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             iCLK,
    input  logic             iRST,
    output logic             oIMemReq,
    output logic [63:0]      oIMemAddr,
    input  logic             iIMemAck,
    input  logic [31:0]      iIMemData,
    output logic             oInstrValid,
    input  logic             iInstrReady,
    input  logic             iStall,
    output logic [31:0]      oInstruction,
    output logic [63:0]      oPC,
    output logic [63:0]      oPCPlus4,
    input  logic             iBranchTaken,
    input  logic [63:0]      iBranchOffset,
    input  logic             iFlush,
    input  logic [63:0]      iFlushPC,
`ifdef FETCH_PERF_EN
    output logic [CNT_W-1:0] oFetchCount,
    output logic [CNT_W-1:0] oStallCycles,
`endif
    output logic [1:0]       dbg_state
);

    // Handshakes: a memory transfer completes on any edge where oIMemReq && iIMemAck;
    // an instruction is consumed on any edge where oInstrValid && iInstrReady && !iStall.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] fetch_pc;
    logic [63:0] flush_pc;
    logic [63:0] next_pc;
    logic        accept;
    logic        unused_flush_bits;

    assign flush_pc          = {iFlushPC[63:2], 2'b00};
    assign accept            = iInstrReady & ~iStall;
    assign next_pc           = iBranchTaken ? (oPC + (iBranchOffset << 2)) : oPCPlus4;
    assign unused_flush_bits = &{1'b0, iFlushPC[1:0]};
    assign dbg_state         = state;

    // fetch_pc equals oIMemAddr except in DRAIN, where it holds the flush target
    // while oIMemAddr stays on the request that cannot be abandoned.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            oIMemReq     <= 1'b0;
            oIMemAddr    <= RESET_PC;
            oInstrValid  <= 1'b0;
            oInstruction <= 32'h0;
            oPC          <= RESET_PC;
            oPCPlus4     <= RESET_PC + 64'd4;
        end else begin
            case (state)
                IDLE: begin
                    oIMemReq <= 1'b1;
                    state    <= FETCH;
                    if (iFlush) begin
                        fetch_pc  <= flush_pc;
                        oIMemAddr <= flush_pc;
                    end
                end
                FETCH: begin
                    if (iFlush) begin
                        fetch_pc    <= flush_pc;
                        oInstrValid <= 1'b0;
                        if (iIMemAck) begin
                            oIMemAddr <= flush_pc;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (iIMemAck) begin
                        oInstruction <= iIMemData;
                        oPC          <= oIMemAddr;
                        oPCPlus4     <= oIMemAddr + 64'd4;
                        oInstrValid  <= 1'b1;
                        oIMemReq     <= 1'b0;
                        state        <= HOLD;
                    end
                end
                HOLD: begin
                    if (iFlush) begin
                        fetch_pc    <= flush_pc;
                        oIMemAddr   <= flush_pc;
                        oInstrValid <= 1'b0;
                        oIMemReq    <= 1'b1;
                        state       <= FETCH;
                    end else if (accept) begin
                        fetch_pc    <= next_pc;
                        oIMemAddr   <= next_pc;
                        oInstrValid <= 1'b0;
                        oIMemReq    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                DRAIN: begin
                    oInstrValid <= 1'b0;
                    if (iFlush) begin
                        fetch_pc <= flush_pc;
                        if (iIMemAck) begin
                            oIMemAddr <= flush_pc;
                            state     <= FETCH;
                        end
                    end else if (iIMemAck) begin
                        oIMemAddr <= fetch_pc;
                        state     <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    oIMemReq <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters; a flush that overrides an accept does not count as a fetch.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oFetchCount  <= '0;
            oStallCycles <= '0;
        end else begin
            if (state == HOLD && accept && !iFlush && oFetchCount != {CNT_W{1'b1}}) begin
                oFetchCount <= oFetchCount + 1'b1;
            end
            if (state == HOLD && iStall && oStallCycles != {CNT_W{1'b1}}) begin
                oStallCycles <= oStallCycles + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised bench for instruction_fetch_unit: memory responder, datapath driver tasks,
// and a monitor that checks each presented instruction against a PC-sequence model.
module tb_instruction_fetch_unit;

    localparam logic [63:0] RESET_PC = 64'h0;

    logic        iCLK;
    logic        iRST;
    logic        oIMemReq;
    logic [63:0] oIMemAddr;
    logic        iIMemAck;
    logic [31:0] iIMemData;
    logic        oInstrValid;
    logic        iInstrReady;
    logic        iStall;
    logic [31:0] oInstruction;
    logic [63:0] oPC;
    logic [63:0] oPCPlus4;
    logic        iBranchTaken;
    logic [63:0] iBranchOffset;
    logic        iFlush;
    logic [63:0] iFlushPC;
    logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;
`endif

    instruction_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(32)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .oIMemReq(oIMemReq), .oIMemAddr(oIMemAddr),
        .iIMemAck(iIMemAck), .iIMemData(iIMemData),
        .oInstrValid(oInstrValid), .iInstrReady(iInstrReady), .iStall(iStall),
        .oInstruction(oInstruction), .oPC(oPC), .oPCPlus4(oPCPlus4),
        .iBranchTaken(iBranchTaken), .iBranchOffset(iBranchOffset),
        .iFlush(iFlush), .iFlushPC(iFlushPC),
`ifdef FETCH_PERF_EN
        .oFetchCount(fetch_count), .oStallCycles(stall_cycles),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_pc;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Memory image: each word derived from its address so stale data is recognisable.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hF800_0001;
    endfunction

    // ---------------- instruction memory responder ----------------
    int mem_cnt  = 0;
    int ack_lat  = 1;
    bit rand_lat = 0;
    bit mem_hold = 0;
    bit spur_en  = 0;

    always @(negedge iCLK) begin
        if (!iRST) begin
            iIMemAck = 1'b0;
            mem_cnt  = 0;
        end else if (oIMemReq && !mem_hold) begin
            if (mem_cnt >= ack_lat) begin
                iIMemAck  = 1'b1;
                iIMemData = mem_word(oIMemAddr);
                mem_cnt   = 0;
                if (rand_lat) ack_lat = $urandom_range(0, 3);
            end else begin
                iIMemAck = 1'b0;
                mem_cnt++;
            end
        end else begin
            iIMemAck  = !oIMemReq && spur_en && ($urandom_range(0, 7) == 0);
            iIMemData = $urandom;
            if (!oIMemReq) mem_cnt = 0;
        end
    end

    // ---------------- monitor ----------------
    bit          prev_valid  = 0;
    bit          chk_req_next = 0;
    bit          period_chk  = 0;
    int          cyc         = 0;
    int          last_rise   = -1;
    logic [63:0] mon_pc      = 64'h0;

    always @(posedge iCLK) begin
        #1;
        cyc++;
        if (!iRST) begin
            prev_valid = 0;
        end else begin
            if (chk_req_next) begin
                check(oIMemReq === 1'b1, "req_after_accept", {63'h0, oIMemReq}, 64'h1);
                chk_req_next = 0;
            end
            if (oInstrValid && !prev_valid) begin
                if (exp_q.size() == 0) check(1'b0, "unexpected_valid", oPC, 64'h0);
                else mon_pc = exp_q.pop_front();
                if (period_chk && last_rise >= 0)
                    check(cyc - last_rise == 3, "valid_period", 64'(cyc - last_rise), 64'd3);
                last_rise = cyc;
            end
            if (oInstrValid) begin
                check(oPC === mon_pc, "pc", oPC, mon_pc);
                check(oPCPlus4 === mon_pc + 64'd4, "pc_plus4", oPCPlus4, mon_pc + 64'd4);
                check(oInstruction === mem_word(mon_pc), "instruction", {32'h0, oInstruction}, {32'h0, mem_word(mon_pc)});
                check(oIMemReq === 1'b0, "no_req_in_hold", {63'h0, oIMemReq}, 64'h0);
            end
            prev_valid = oInstrValid;
        end
    end

    // ---------------- datapath driver tasks ----------------
    task automatic wait_valid();
        int t = 0;
        while (!oInstrValid && t < 60) begin
            @(negedge iCLK);
            t++;
        end
        if (!oInstrValid) check(1'b0, "valid_timeout", 64'(t), 64'd60);
    endtask

    task automatic check_next_req(input logic [63:0] addr, input string name);
        int t = 0;
        while (!oIMemReq && t < 20) begin
            @(negedge iCLK);
            t++;
        end
        check(oIMemReq && oIMemAddr === addr, name, oIMemAddr, addr);
    endtask

    task automatic do_accept(input bit bt, input logic [63:0] off);
        iInstrReady   = 1'b1;
        iStall        = 1'b0;
        iBranchTaken  = bt;
        iBranchOffset = off;
        model_pc      = bt ? model_pc + off * 64'd4 : model_pc + 64'd4;
        exp_q.push_back(model_pc);
        chk_req_next  = 1;
        @(negedge iCLK);
        iInstrReady   = 1'b0;
        iBranchTaken  = 1'b0;
        iBranchOffset = {$urandom, $urandom};
    endtask

    task automatic do_flush(input logic [63:0] pc, input bit with_accept);
        iFlush        = 1'b1;
        iFlushPC      = pc;
        iInstrReady   = with_accept;
        iStall        = 1'b0;
        iBranchTaken  = with_accept;
        iBranchOffset = 64'h10;
        exp_q.delete();
        model_pc      = pc & ~64'h3;
        exp_q.push_back(model_pc);
        @(negedge iCLK);
        iFlush        = 1'b0;
        iInstrReady   = 1'b0;
        iBranchTaken  = 1'b0;
    endtask

    function automatic logic [63:0] rand_off();
        int s;
        if ($urandom_range(0, 7) == 0) return {$urandom, $urandom};
        s = int'($urandom_range(0, 256)) - 128;
        return 64'(s);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        iRST = 1'b1; iIMemAck = 1'b0; iIMemData = 32'h0;
        iInstrReady = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0; iBranchOffset = 64'h0;
        iFlush = 1'b0; iFlushPC = 64'h0;
        model_pc = RESET_PC;
        exp_q.push_back(RESET_PC);
        #3 iRST = 1'b0;
        #9;
        check(oIMemReq === 1'b0, "rst_req", {63'h0, oIMemReq}, 64'h0);
        check(oIMemAddr === RESET_PC, "rst_addr", oIMemAddr, RESET_PC);
        check(oInstrValid === 1'b0, "rst_valid", {63'h0, oInstrValid}, 64'h0);
        check(oInstruction === 32'h0, "rst_instr", {32'h0, oInstruction}, 64'h0);
        check(oPC === RESET_PC, "rst_pc", oPC, RESET_PC);
        check(oPCPlus4 === RESET_PC + 64'd4, "rst_pc4", oPCPlus4, RESET_PC + 64'd4);
        check(dbg_state === 2'd0, "rst_state", {62'h0, dbg_state}, 64'h0);
        @(negedge iCLK);
        iRST = 1'b1;

        // Sequential fetch, ack one cycle after each request: 0,4,8,C.
        check_next_req(64'h0, "first_req");
        period_chk = 1;
        for (int i = 1; i <= 4; i++) begin
            wait_valid();
            do_accept(1'b0, 64'h0);
            check_next_req(64'(4 * i), "seq_addr");
        end
        wait_valid();
        period_chk = 0;

        // Backward branch from 0x100 by two words.
        do_flush(64'h100, 1'b0);
        wait_valid();
        do_accept(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        check_next_req(64'hF8, "branch_target");

        // Four stall cycles in HOLD, accept on the fifth.
        wait_valid();
        for (int i = 0; i < 4; i++) begin
            iStall = 1'b1; iInstrReady = 1'b1; iBranchTaken = 1'b1;
            @(negedge iCLK);
            check(oInstrValid && !oIMemReq, "stall_hold", {62'h0, oInstrValid, oIMemReq}, 64'h2);
        end
        do_accept(1'b0, 64'h0);
`ifdef FETCH_PERF_EN
        check(stall_cycles === 32'd4, "stall_count", {32'h0, stall_cycles}, 64'd4);
`endif

        // Flush while the request to 0x40 is outstanding.
        wait_valid();
        mem_hold = 1;
        do_flush(64'h40, 1'b0);
        check(oIMemReq && oIMemAddr === 64'h40, "req_0x40", oIMemAddr, 64'h40);
        ack_lat = 3;
        mem_hold = 0;
        do_flush(64'h2003, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (oIMemAddr !== 64'h40) break;
            check(oIMemReq === 1'b1, "drain_req", {63'h0, oIMemReq}, 64'h1);
            @(negedge iCLK);
        end
        check(oIMemReq && oIMemAddr === 64'h2000, "restart_0x2000", oIMemAddr, 64'h2000);
        wait_valid();

        // PC wrap at the top of the address space.
        ack_lat = 0;
        do_flush(64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        wait_valid();
        do_accept(1'b0, 64'h0);
        check_next_req(64'h0, "wrap_addr");

        // Flush beats a simultaneous taken-branch accept.
        wait_valid();
        do_flush(64'h3000, 1'b1);
        check_next_req(64'h3000, "flush_over_accept");

        // Asynchronous reset in the middle of a fetch.
        ack_lat = 2;
        wait_valid();
        do_accept(1'b0, 64'h0);
        #2 iRST = 1'b0;
        #1;
        check(oIMemReq === 1'b0, "async_rst_req", {63'h0, oIMemReq}, 64'h0);
        check(oInstrValid === 1'b0, "async_rst_valid", {63'h0, oInstrValid}, 64'h0);
        exp_q.delete();
        model_pc = RESET_PC;
        exp_q.push_back(RESET_PC);
        repeat (2) @(negedge iCLK);
        iRST = 1'b1;
        check_next_req(RESET_PC, "restart_after_reset");

        // Randomised traffic.
        rand_lat = 1;
        spur_en  = 1;
        repeat (300) begin
            int n;
            int r;
            wait_valid();
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                iStall       = 1'($urandom_range(0, 1));
                iInstrReady  = iStall ? 1'($urandom_range(0, 1)) : 1'b0;
                iBranchTaken = 1'($urandom_range(0, 1));
                @(negedge iCLK);
            end
            iStall = 1'b0;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                do_flush({$urandom, $urandom}, 1'b0);
            end else if (r == 1) begin
                do_flush({$urandom, $urandom}, 1'b1);
            end else begin
                do_accept($urandom_range(0, 2) == 0, rand_off());
                if ($urandom_range(0, 5) == 0) begin
                    repeat ($urandom_range(0, 2)) @(negedge iCLK);
                    do_flush({$urandom, $urandom}, 1'b0);
                end
            end
        end
        wait_valid();
        @(negedge iCLK);
        check(exp_q.size() == 0, "queue_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
